// File: rtl/pit_8253.sv
// 8253-style programmable interval timer for a PC-compatible core.
// Channels 0 and 2 are implemented. Channel 1 is absent.
// Channel 0 drives IRQ0. Channel 2 drives the speaker and is gated by iGate2.
// Counting is binary only. Counters advance on a ~1.19 MHz tick derived from iClk.

// One counter channel: control word, count load, latch, readback and the
// mode 0/2/3 counting engine.
module pit_8253_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       gate,
    input  logic       ctrl_wr,
    input  logic       latch_cmd,
    input  logic       data_wr,
    input  logic       rd_done,
    input  logic [7:0] wdata,
    output logic [7:0] rd_byte,
    output logic       out
);

    typedef enum logic [1:0] {
        MODE0 = 2'b00,
        MODE2 = 2'b10,
        MODE3 = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        RW_LATCH = 2'b00,
        RW_LSB   = 2'b01,
        RW_MSB   = 2'b10,
        RW_WORD  = 2'b11
    } rw_e;

    mode_e       mode;
    rw_e         rw;
    logic [15:0] count;
    logic [7:0]  wr_lsb;
    logic        wr_tog;
    logic        rd_tog;
    logic [16:0] ce;
    logic [15:0] latch_val;
    logic        latched;
    logic        armed;
    logic        init_pending;
    logic        running;
    logic        gate_q;

    logic [16:0] n_raw;
    logic [16:0] n_rep;
    logic [16:0] half_hi;
    logic [16:0] half_lo;
    logic [16:0] init_val;
    logic [15:0] new_count;
    logic [15:0] rd_src;
    logic        gate_rise;
    logic        unused_ctrl_bits;

    // SC is decoded by the parent. BCD is unsupported. Mode bit 2 only
    // distinguishes modes that behave identically here.
    assign unused_ctrl_bits = ^{wdata[7:6], wdata[3], wdata[0]};

    // A count of zero stands for 65536.
    // The periodic modes cannot run with a count of 1, so they use 2.
    assign n_raw   = (count == 16'd0) ? 17'h10000 : {1'b0, count};
    assign n_rep   = (n_raw == 17'd1) ? 17'd2 : n_raw;
    assign half_hi = n_rep + {16'd0, n_rep[0]};
    assign half_lo = n_rep - {16'd0, n_rep[0]};

    assign gate_rise = gate & ~gate_q;

    // Initial counter value and assembled reload value for the current mode and RW.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        init_val  = n_rep;
        new_count = count;
        case (mode)
            MODE0:   init_val = n_raw;
            MODE2:   init_val = n_rep;
            default: init_val = half_hi;
        endcase
        case (rw)
            RW_LSB:  new_count = {8'h00, wdata};
            RW_MSB:  new_count = {wdata, 8'h00};
            RW_WORD: new_count = {wdata, wr_lsb};
            default: new_count = count;
        endcase
    end

    // Readback byte: the held latch takes priority over the live counter.
    always_comb begin
        rd_src = latched ? latch_val : ce[15:0];
        case (rw)
            RW_MSB:  rd_byte = rd_src[15:8];
            RW_WORD: rd_byte = rd_tog ? rd_src[15:8] : rd_src[7:0];
            default: rd_byte = rd_src[7:0];
        endcase
    end

    // Channel state. A CPU access to this channel takes precedence over the tick in that cycle.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            // NOTE: the reset clears every register. This block has no memory array that could skip reset.
            mode         <= MODE0;
            rw           <= RW_LATCH;
            count        <= '0;
            wr_lsb       <= '0;
            wr_tog       <= 1'b0;
            rd_tog       <= 1'b0;
            ce           <= '0;
            latch_val    <= '0;
            latched      <= 1'b0;
            armed        <= 1'b0;
            init_pending <= 1'b0;
            running      <= 1'b0;
            gate_q       <= 1'b0;
            out          <= 1'b0;
        end else begin
            gate_q <= gate;

            if (rd_done) begin
                if (rw == RW_WORD)
                    rd_tog <= ~rd_tog;
                if (latched && (rw != RW_WORD || rd_tog))
                    latched <= 1'b0;
            end

            if (latch_cmd && !latched) begin
                latch_val <= ce[15:0];
                latched   <= 1'b1;
            end

            if (ctrl_wr) begin
                mode         <= mode_e'(wdata[2] ? {1'b1, wdata[1]} : 2'b00);
                rw           <= rw_e'(wdata[5:4]);
                wr_tog       <= 1'b0;
                rd_tog       <= 1'b0;
                latched      <= 1'b0;
                armed        <= 1'b0;
                init_pending <= 1'b0;
                running      <= 1'b0;
                out          <= wdata[2];
            end else if (data_wr) begin
                if (rw == RW_WORD && !wr_tog) begin
                    wr_lsb <= wdata;
                    wr_tog <= 1'b1;
                end else if (rw != RW_LATCH) begin
                    count  <= new_count;
                    wr_tog <= 1'b0;
                    armed  <= 1'b1;
                    if (mode == MODE0) begin
                        out          <= 1'b0;
                        running      <= 1'b0;
                        init_pending <= 1'b1;
                    end else if (!armed) begin
                        init_pending <= 1'b1;
                    end
                end
            end else if (!latch_cmd) begin
                if (gate_rise) begin
                    if (armed) begin
                        init_pending <= 1'b1;
                        running      <= 1'b0;
                    end
                end else if (!gate) begin
                    if (mode != MODE0)
                        out <= 1'b1;
                end else if (tick) begin
                    if (init_pending) begin
                        ce           <= init_val;
                        init_pending <= 1'b0;
                        running      <= 1'b1;
                        if (mode != MODE0)
                            out <= 1'b1;
                    end else if (running) begin
                        case (mode)
                            MODE0: begin
                                if (ce == 17'd1)
                                    out <= 1'b1;
                                ce <= (ce == 17'd0) ? 17'h0FFFF : ce - 17'd1;
                            end
                            MODE2: begin
                                if (ce == 17'd2) begin
                                    ce  <= 17'd1;
                                    out <= 1'b0;
                                end else if (ce <= 17'd1) begin
                                    ce  <= n_rep;
                                    out <= 1'b1;
                                end else begin
                                    ce <= ce - 17'd1;
                                end
                            end
                            default: begin
                                if (ce <= 17'd2) begin
                                    out <= ~out;
                                    ce  <= out ? half_lo : half_hi;
                                end else begin
                                    ce <= ce - 17'd2;
                                end
                            end
                        endcase
                    end
                end
            end
        end
    end

endmodule

// Top level: tick generator, IO decode and the two counter channels.
module pit_8253 #(
    parameter int unsigned TICK_STEP = 7820,
    parameter int unsigned ACC_W     = 16
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic [19:0] iAddr,
    input  logic [7:0]  iData,
    input  logic        iIoWr,
    input  logic        iIoRd,
    input  logic        iGate2,
    output logic        oSel,
    output logic [7:0]  oData,
    output logic        oIrq0,
    output logic        oSpk
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   acc_sum;
    logic             tick;
    logic             hit;
    logic [1:0]       port;
    logic             cw_wr;
    logic             cw_is_latch;
    logic             cw_ch0;
    logic             cw_ch2;
    logic [7:0]       ch0_byte;
    logic [7:0]       ch2_byte;
    logic             unused_addr_hi;

    assign unused_addr_hi = ^iAddr[19:16];

    assign acc_sum = {1'b0, acc} + (ACC_W + 1)'(TICK_STEP);
    assign tick    = acc_sum[ACC_W];

    // Phase accumulator. Its carry out is the counter tick.
    always_ff @(posedge iClk) begin
        if (iRst)
            acc <= '0;
        else
            acc <= acc_sum[ACC_W-1:0];
    end

    assign hit         = (iAddr[15:2] == 14'h0010);
    assign port        = iAddr[1:0];
    assign cw_wr       = iIoWr & hit & (port == 2'd3);
    assign cw_is_latch = (iData[5:4] == 2'b00);
    assign cw_ch0      = cw_wr & (iData[7:6] == 2'b00);
    assign cw_ch2      = cw_wr & (iData[7:6] == 2'b10);

    pit_8253_counter u_ch0 (
        .clk       (iClk),
        .rst       (iRst),
        .tick      (tick),
        .gate      (1'b1),
        .ctrl_wr   (cw_ch0 & ~cw_is_latch),
        .latch_cmd (cw_ch0 & cw_is_latch),
        .data_wr   (iIoWr & hit & (port == 2'd0)),
        .rd_done   (iIoRd & hit & (port == 2'd0)),
        .wdata     (iData),
        .rd_byte   (ch0_byte),
        .out       (oIrq0)
    );

    pit_8253_counter u_ch2 (
        .clk       (iClk),
        .rst       (iRst),
        .tick      (tick),
        .gate      (iGate2),
        .ctrl_wr   (cw_ch2 & ~cw_is_latch),
        .latch_cmd (cw_ch2 & cw_is_latch),
        .data_wr   (iIoWr & hit & (port == 2'd2)),
        .rd_done   (iIoRd & hit & (port == 2'd2)),
        .wdata     (iData),
        .rd_byte   (ch2_byte),
        .out       (oSpk)
    );

    assign oSel = iIoRd & hit;

    // Read-data mux. The absent channel 1 and the control port read as all ones.
    always_comb begin
        oData = 8'hFF;
        case (port)
            2'd0:    oData = ch0_byte;
            2'd2:    oData = ch2_byte;
            default: oData = 8'hFF;
        endcase
    end

endmodule

// File: tb/tb_pit_8253.sv
// Directed bench for pit_8253: register decode vectors plus timed counting sequences.
module tb_pit_8253;

    localparam int STEP = 7820;

    logic        iClk = 1'b0;
    logic        iRst = 1'b1;
    logic [19:0] iAddr = '0;
    logic [7:0]  iData = '0;
    logic        iIoWr = 1'b0;
    logic        iIoRd = 1'b0;
    logic        iGate2 = 1'b1;
    logic        oSel;
    logic [7:0]  oData;
    logic        oIrq0;
    logic        oSpk;

    pit_8253 #(.TICK_STEP(STEP), .ACC_W(16)) dut (
        .iClk   (iClk),
        .iRst   (iRst),
        .iAddr  (iAddr),
        .iData  (iData),
        .iIoWr  (iIoWr),
        .iIoRd  (iIoRd),
        .iGate2 (iGate2),
        .oSel   (oSel),
        .oData  (oData),
        .oIrq0  (oIrq0),
        .oSpk   (oSpk)
    );

    always #5 iClk = ~iClk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference tick timing, tracking which clock edges carry a counter tick.
    int bacc  = 0;
    int ticks = 0;
    always @(posedge iClk) begin
        if (iRst) begin
            bacc <= 0;
        end else begin
            if (bacc + STEP >= 65536)
                ticks <= ticks + 1;
            bacc <= (bacc + STEP) % 65536;
        end
    end

    typedef struct {
        bit          wr;
        logic [19:0] addr;
        logic [7:0]  data;
        bit          sel;
        logic [7:0]  rdat;
        bit          irq;
        bit          spk;
    } vec_t;

    localparam int NVEC = 25;
    vec_t vecs[NVEC];

    logic [7:0] rd_d;
    logic       rd_s;
    int         t_a;
    int         t_b;
    logic [15:0] exp_ce;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    // Advance to just after the next tick edge.
    task automatic wait_tick();
        int t0;
        int n;
        t0 = ticks;
        n  = 0;
        do begin
            step();
            n++;
        end while (ticks == t0 && n < 40);
        if (ticks == t0) begin
            n_tests++;
            n_fail++;
            $display("FAIL tick_wait: no tick within %0d cycles", n);
        end
    endtask

    // Advance until the coming clock edge carries a tick.
    task automatic wait_pre_tick();
        int n;
        n = 0;
        while (bacc + STEP < 65536 && n < 40) begin
            step();
            n++;
        end
    endtask

    task automatic io_wr(input logic [19:0] a, input logic [7:0] d);
        iAddr = a;
        iData = d;
        iIoWr = 1'b1;
        step();
        iIoWr = 1'b0;
    endtask

    task automatic io_rd(input logic [19:0] a, output logic [7:0] d, output logic s);
        iAddr = a;
        iIoRd = 1'b1;
        #1;
        d = oData;
        s = oSel;
        @(posedge iClk);
        #1;
        iIoRd = 1'b0;
    endtask

    task automatic rd_check(input logic [19:0] a, input logic [7:0] exp, input string name);
        logic [7:0] d;
        logic       s;
        io_rd(a, d, s);
        check(name, {24'd0, d}, {24'd0, exp});
    endtask

    task automatic do_reset();
        iRst = 1'b1;
        step();
        step();
        iRst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        //          wr  addr        data   sel  rdat   irq spk
        vecs[0]  = '{0, 20'h00040, 8'h00, 1, 8'h00, 0, 0};
        vecs[1]  = '{0, 20'h00041, 8'h00, 1, 8'hFF, 0, 0};
        vecs[2]  = '{0, 20'h00042, 8'h00, 1, 8'h00, 0, 0};
        vecs[3]  = '{0, 20'hF0040, 8'h00, 1, 8'h00, 0, 0};
        vecs[4]  = '{0, 20'h00044, 8'h00, 0, 8'h00, 0, 0};
        vecs[5]  = '{0, 20'h0003F, 8'h00, 0, 8'h00, 0, 0};
        vecs[6]  = '{1, 20'h00043, 8'h34, 0, 8'h00, 1, 0};
        vecs[7]  = '{1, 20'h00043, 8'h74, 0, 8'h00, 1, 0};
        vecs[8]  = '{1, 20'h00043, 8'hF6, 0, 8'h00, 1, 0};
        vecs[9]  = '{1, 20'h00043, 8'hB6, 0, 8'h00, 1, 1};
        vecs[10] = '{1, 20'h00043, 8'h12, 0, 8'h00, 0, 1};
        vecs[11] = '{1, 20'h00043, 8'h1C, 0, 8'h00, 1, 1};
        vecs[12] = '{1, 20'h00043, 8'h18, 0, 8'h00, 0, 1};
        vecs[13] = '{1, 20'h00043, 8'h1E, 0, 8'h00, 1, 1};
        vecs[14] = '{1, 20'h00043, 8'h1A, 0, 8'h00, 0, 1};
        vecs[15] = '{1, 20'h00043, 8'h90, 0, 8'h00, 0, 0};
        vecs[16] = '{1, 20'h00043, 8'h96, 0, 8'h00, 0, 1};
        vecs[17] = '{1, 20'h00041, 8'h55, 0, 8'h00, 0, 1};
        vecs[18] = '{0, 20'h00041, 8'h00, 1, 8'hFF, 0, 1};
        vecs[19] = '{0, 20'h00040, 8'h00, 1, 8'h00, 0, 1};
        vecs[20] = '{1, 20'hF0043, 8'h34, 0, 8'h00, 1, 1};
        vecs[21] = '{1, 20'h00047, 8'h10, 0, 8'h00, 1, 1};
        vecs[22] = '{0, 20'h00040, 8'h00, 1, 8'h00, 1, 1};
        vecs[23] = '{0, 20'h00040, 8'h00, 1, 8'h00, 1, 1};
        vecs[24] = '{0, 20'h00042, 8'h00, 1, 8'h00, 1, 1};

        do_reset();
        check("rst_irq0", {31'd0, oIrq0}, 32'd0);
        check("rst_spk", {31'd0, oSpk}, 32'd0);

        // Decode, control-word mapping and idle readback.
        for (int i = 0; i < NVEC; i++) begin
            if (vecs[i].wr) begin
                io_wr(vecs[i].addr, vecs[i].data);
            end else begin
                io_rd(vecs[i].addr, rd_d, rd_s);
                check($sformatf("vec%0d_sel", i), {31'd0, rd_s}, {31'd0, vecs[i].sel});
                if (vecs[i].sel)
                    check($sformatf("vec%0d_data", i), {24'd0, rd_d}, {24'd0, vecs[i].rdat});
            end
            check($sformatf("vec%0d_irq0", i), {31'd0, oIrq0}, {31'd0, vecs[i].irq});
            check($sformatf("vec%0d_spk", i), {31'd0, oSpk}, {31'd0, vecs[i].spk});
        end

        // Mode 2, N=4: one low tick every four ticks.
        do_reset();
        wait_tick();
        io_wr(20'h00043, 8'h34);
        io_wr(20'h00040, 8'h04);
        io_wr(20'h00040, 8'h00);
        check("m2_loaded_high", {31'd0, oIrq0}, 32'd1);
        wait_tick();
        check("m2_init_high", {31'd0, oIrq0}, 32'd1);
        for (int k = 1; k <= 12; k++) begin
            wait_tick();
            check($sformatf("m2_n4_tick%0d", k), {31'd0, oIrq0}, (k % 4 == 3) ? 32'd0 : 32'd1);
        end
        // A new count written while loaded applies only at the next reload.
        io_wr(20'h00040, 8'h06);
        io_wr(20'h00040, 8'h00);
        for (int k = 13; k <= 22; k++) begin
            wait_tick();
            check($sformatf("m2_reload_tick%0d", k), {31'd0, oIrq0}, (k == 15 || k == 21) ? 32'd0 : 32'd1);
        end

        // Latch command in mode 2 with N=0x1000.
        wait_tick();
        io_wr(20'h00043, 8'h34);
        io_wr(20'h00040, 8'h00);
        io_wr(20'h00040, 8'h10);
        wait_tick();
        for (int k = 0; k < 5; k++) wait_tick();
        io_wr(20'h00043, 8'h00);
        wait_tick();
        wait_tick();
        io_wr(20'h00043, 8'h00);
        for (int k = 0; k < 8; k++) wait_tick();
        rd_check(20'h00040, 8'hFB, "latch_lsb");
        rd_check(20'h00040, 8'h0F, "latch_msb");
        rd_check(20'h00040, 8'hF1, "live_lsb");
        rd_check(20'h00040, 8'h0F, "live_msb");

        // A write discards a coincident tick only for the addressed channel.
        t_a = ticks;
        wait_pre_tick();
        io_wr(20'h00041, 8'h00);
        wait_pre_tick();
        io_wr(20'h00040, 8'h00);
        io_wr(20'h00040, 8'h10);
        wait_tick();
        t_b = ticks;
        exp_ce = 16'h0FF1 - 16'(t_b - t_a - 1);
        rd_check(20'h00040, exp_ce[7:0], "discard_lsb");
        rd_check(20'h00040, exp_ce[15:8], "discard_msb");

        // Mode 0, N=3: terminal count, then wrap without affecting OUT.
        wait_tick();
        io_wr(20'h00043, 8'h30);
        check("m0_ctrl_low", {31'd0, oIrq0}, 32'd0);
        io_wr(20'h00040, 8'h03);
        io_wr(20'h00040, 8'h00);
        check("m0_load_low", {31'd0, oIrq0}, 32'd0);
        wait_tick();
        check("m0_init_low", {31'd0, oIrq0}, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            wait_tick();
            check($sformatf("m0_n3_tick%0d", k), {31'd0, oIrq0}, (k >= 3) ? 32'd1 : 32'd0);
        end
        rd_check(20'h00040, 8'hFF, "m0_wrap_lsb");
        rd_check(20'h00040, 8'hFF, "m0_wrap_msb");
        wait_tick();
        check("m0_wrap_high", {31'd0, oIrq0}, 32'd1);
        io_wr(20'h00040, 8'h05);
        io_wr(20'h00040, 8'h00);
        check("m0_rewrite_low", {31'd0, oIrq0}, 32'd0);
        wait_tick();
        for (int k = 1; k <= 5; k++) begin
            wait_tick();
            check($sformatf("m0_n5_tick%0d", k), {31'd0, oIrq0}, (k == 5) ? 32'd1 : 32'd0);
        end

        // Mode 3 on channel 2, N=5: three high ticks, two low.
        wait_tick();
        io_wr(20'h00043, 8'hB6);
        check("m3_ctrl_high", {31'd0, oSpk}, 32'd1);
        io_wr(20'h00042, 8'h05);
        io_wr(20'h00042, 8'h00);
        wait_tick();
        check("m3_tick0", {31'd0, oSpk}, 32'd1);
        for (int k = 1; k <= 13; k++) begin
            wait_tick();
            check($sformatf("m3_tick%0d", k), {31'd0, oSpk}, (k % 5 < 3) ? 32'd1 : 32'd0);
        end
        // Gate low forces OUT high and freezes CE at 4.
        iGate2 = 1'b0;
        step();
        check("gate_low_high", {31'd0, oSpk}, 32'd1);
        rd_check(20'h00042, 8'h04, "gate_ce_lsb0");
        rd_check(20'h00042, 8'h00, "gate_ce_msb0");
        for (int k = 0; k < 3; k++) wait_tick();
        check("gate_low_still_high", {31'd0, oSpk}, 32'd1);
        rd_check(20'h00042, 8'h04, "gate_ce_lsb1");
        rd_check(20'h00042, 8'h00, "gate_ce_msb1");
        // Gate rise restarts from the initial value on the next tick.
        iGate2 = 1'b1;
        for (int g = 0; g <= 5; g++) begin
            wait_tick();
            check($sformatf("gate_rise_tick%0d", g), {31'd0, oSpk}, (g % 5 < 3) ? 32'd1 : 32'd0);
        end

        // Reset mid-count clears outputs and channel state.
        check("pre_rst_irq0", {31'd0, oIrq0}, 32'd1);
        iRst = 1'b1;
        step();
        check("midrst_irq0", {31'd0, oIrq0}, 32'd0);
        check("midrst_spk", {31'd0, oSpk}, 32'd0);
        iRst = 1'b0;
        rd_check(20'h00040, 8'h00, "midrst_rd_ch0");
        rd_check(20'h00042, 8'h00, "midrst_rd_ch2");
        for (int k = 0; k < 3; k++) wait_tick();
        rd_check(20'h00040, 8'h00, "midrst_rd_ch0_later");
        check("midrst_irq0_later", {31'd0, oIrq0}, 32'd0);
        io_wr(20'h00043, 8'h34);
        wait_tick();
        wait_tick();
        rd_check(20'h00040, 8'h00, "ctrl_only_no_count");
        check("ctrl_only_irq0", {31'd0, oIrq0}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pit_8253.md
PIT_8253 -- requirements
Module: pit_8253

Interface
REQ-001 Parameter TICK_STEP, default 7820, phase-accumulator increment per iClk (about 1.1932 MHz ticks from 10 MHz).
REQ-002 Parameter ACC_W, default 16, phase-accumulator width.
REQ-003 iClk  input  1  system clock (pll_clk10 domain); the only clock.
REQ-004 iRst  input  1  reset, synchronous, active-high.
REQ-005 iAddr  input  20  CPU address; the block is hit when iAddr[15:2] == 14'h0010 (ports 0x40-0x43); iAddr[19:16] are ignored.
REQ-006 iData  input  8  CPU write data.
REQ-007 iIoWr  input  1  single-cycle IO write strobe.
REQ-008 iIoRd  input  1  single-cycle IO read strobe.
REQ-009 iGate2  input  1  channel 2 gate (port 0x61 bit 0).
REQ-010 oSel  output  1  combinational, equal to iIoRd AND hit; drives the CPU read-data mux.
REQ-011 oData  output  8  combinational read data; valid while oSel is high.
REQ-012 oIrq0  output  1  registered channel 0 OUT; drives the PIC iIrq0 input.
REQ-013 oSpk  output  1  registered channel 2 OUT (speaker).

Function
REQ-014 Tick generator: acc <= acc + TICK_STEP every cycle; tick is the carry out of bit ACC_W-1.
REQ-015 Only channels 0 and 2 are implemented; channel 1 writes are ignored and channel 1 reads return 8'hFF; channel 0 gate is tied high.
REQ-016 Control word (port 0x43): [7:6] SC selects 00=ch0, 10=ch2; 01 and 11 are ignored. [5:4] RW: 00=latch, 01=LSB only, 10=MSB only, 11=LSB then MSB. [3:1] mode. [0] BCD is ignored (binary counting only).
REQ-017 Mode mapping: 0->0, 2 and 6->2, 3 and 7->3; modes 1, 4 and 5 behave as mode 0.
REQ-018 Control word with RW != 00: stores mode and RW, resets the write and read byte toggles to LSB, clears any latch, and marks the channel unloaded (counting stops). OUT goes low in mode 0 and high in modes 2/3.
REQ-019 Count write: RW=01 takes a single byte (MSB=0); RW=10 takes a single byte (LSB=0); RW=11 takes LSB then MSB. The load completes on the final byte. Reload value N=0 means 65536.
REQ-020 CE is 17 bits wide. On the first tick after a load completes on an unloaded channel, CE takes its initial value per mode; counting starts on the following tick.
REQ-021 Mode 0: OUT goes low when a load completes. CE decrements by 1 per tick. OUT goes high on the tick CE reaches 0 and stays high. CE then wraps 0->FFFF and continues without affecting OUT. A new count written mid-count drives OUT low and restarts.
REQ-022 Mode 2: CE initial value is N. On a tick with CE==2, CE becomes 1 and OUT goes low. On the next tick OUT goes high and CE reloads to N. Period is N ticks, with OUT low for 1 tick. N=1 is treated as 2.
REQ-023 Mode 3: CE decrements by 2 per tick. For the high phase CE loads N+(N odd); for the low phase CE loads N-(N odd). When CE reaches 0, OUT toggles and CE reloads for the next phase. Result: high lasts ceil(N/2) ticks, low lasts floor(N/2) ticks. N=1 is treated as 2.
REQ-024 In modes 2/3, a count written while the channel is loaded takes effect at the next reload, not immediately.
REQ-025 Channel 2 with iGate2 low: CE holds its value, and OUT is forced high in modes 2/3. On a low->high gate transition, CE reloads its initial value on the next tick.
REQ-026 Latch command: copies CE[15:0] into the latch. Reads then return the latch, in RW order, until fully read, after which the latch is released. A latch command issued while a latch is held is ignored.
REQ-027 Unlatched reads return live CE[15:0] per RW. In RW=11 the read toggle alternates LSB/MSB.
REQ-028 Read side effects (toggle advance, latch release) take effect at the clock edge that ends the iIoRd strobe.
REQ-029 A write and a tick in the same cycle: the write takes effect and the tick is discarded for the addressed channel only.

Reset
REQ-030 On iRst, all of the following are cleared: acc, both CEs, stored counts, latches and toggles. Both channels are set to mode 0 and unloaded. oIrq0=0 and oSpk=0. oSel and oData follow iIoRd combinationally.
REQ-031 iRst asserted mid-count aborts all activity within one cycle. No tick, load or read side effect from that cycle survives.

Verification
REQ-032 Write 0x43=0x34, 0x40=0x04, 0x40=0x00 (mode 2, N=4) -> oIrq0 is low for exactly 1 tick every 4 ticks; a low pulse occurs every 4*65536/TICK_STEP cycles on average.
REQ-033 Write 0x43=0xB6, 0x42=0x05, 0x42=0x00, iGate2=1 -> oSpk is high 3 ticks and low 2 ticks, repeating. Drop iGate2 -> oSpk is forced high and CE freezes.
REQ-034 Write 0x43=0x30, count 0x0003 -> oIrq0 goes low, then high after 3 ticks and stays high while CE wraps to 0xFFFF.
REQ-035 Mode 2 running with N=0x1000: write 0x43=0x00 (latch), wait 10 ticks, read 0x40 twice -> LSB then MSB of the CE at latch time. A third read returns the live LSB.
REQ-036 Assert iRst mid-count -> oIrq0=0 and oSpk=0 the next cycle; reads of 0x40 return 0x00 until a control word and count are loaded.
